alu_op_scheduler: RTL and testbench
===================================

# alu_op_scheduler

Sequencing controller for the shared 4-bit integer ALU datapath. Accepts operation requests from two requesters through valid/ready handshakes and arbitrates between them round-robin. Executes each operation on a single registered operand/ALU path, with shifts run iteratively one bit per cycle, and returns the result, flags and requester ID through a held response handshake.

## Interface
- WIDTH, 4, operand/result width; shift amount always taken from b[1:0]
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; at most one bit high
- req_op0 / req_op1  in  3 each  opcode of requester 0 / 1
- req_a0 / req_a1  in  WIDTH each  operand A of requester 0 / 1
- req_b0 / req_b1  in  WIDTH each  operand B of requester 0 / 1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester that issued the response
- rsp_result  out  WIDTH  result
- rsp_carry  out  1  carry flag
- rsp_zero  out  1  rsp_result == 0
- busy  out  1  state != IDLE

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL (logical), 110 SHR (logical), 111 PASS (result = a).
- Carry rules:
  - ADD: carry = bit WIDTH of a+b.
  - SUB: result = a-b mod 2^WIDTH; carry = 1 when a >= b (no borrow).
  - Logic/PASS: carry = 0.
  - Shifts: carry = last bit shifted out; 0 when shift amount is 0.
- Arbitration, evaluated in IDLE only:
  - Single valid requester wins.
  - Both valid: the requester not granted last wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- req_ready[i] = (state == IDLE) && grant == i; combinational from req_valid and last_grant.
- Transfer occurs on req_valid[i] && req_ready[i]. On transfer: latch op, a, b, id; update last_grant; load shift count from b[1:0].
- FSM:
  - IDLE -> EXEC on transfer.
  - EXEC, non-shift op: compute result and flags into response registers, -> RESP.
  - EXEC, shift op with count > 0: shift working register one bit, record bit out as carry, decrement count, stay in EXEC.
  - EXEC, shift op with count == 0: register result, -> RESP.
  - RESP: hold rsp_valid = 1 with all rsp_* stable; on rsp_ready -> IDLE.
- No request is accepted in EXEC or RESP, and none in the same cycle as the response handshake.
- A requester dropping req_valid before its grant is legal. Once valid is asserted, operands must stay stable until transfer.

## Timing
- Reset values:
  - State IDLE, last_grant = 1.
  - req_ready = 2'b00 until reset_n is deasserted; then per the grant rule.
  - rsp_valid 0, rsp_id 0, rsp_result 0, rsp_carry 0, rsp_zero 0, busy 0.
- Reset asserted mid-operation: in-flight op discarded and all outputs return to reset values immediately. No response is ever emitted for a discarded op.
- Latency, transfer edge T to rsp_valid high:
  - Non-shift op: T+2 edges.
  - Shift by n (0..3): T+2+n edges.
- rsp_ready high at the first rsp_valid cycle: IDLE at the next edge, next transfer one edge later. Minimum issue interval is 3 cycles.
- Response stall: rsp_valid and data hold indefinitely; requests stay blocked; last_grant unchanged.
- Registered outputs: all rsp_* and busy. Only req_ready is combinational.

## Structure
- Package alu_sched_pkg: opcode localparams (OP_ADD..OP_PASS) and state encoding (ST_IDLE, ST_EXEC, ST_RESP).
- Sub-module alu_core: combinational; inputs op, a, b; outputs result and carry for non-shift ops plus single-bit SHL/SHR steps.
- All sequencing, arbitration and handshake logic lives in alu_op_scheduler.

## Test plan
- Reset, then req_valid=01, op ADD, a=0111, b=1010:
  - req_ready=01.
  - Two edges after transfer: rsp_result=0001, carry=1, zero=0, id=0.
- Both valid from reset:
  - First grant to requester 0; after its response, requester 1 granted.
  - With both held valid, grants alternate 0,1,0,1.
- Requester 1, SHL a=0110 b=0011:
  - rsp_valid exactly 5 edges after transfer; result 0000, carry 1, zero 1.
  - busy high throughout.
- Requester 0, SUB a=0011 b=0101, with rsp_ready held low 4 cycles:
  - result 1110, carry 0, held stable.
  - req_ready=00 during the stall; IDLE one edge after rsp_ready.
- Assert reset_n low during EXEC of SHR a=1000 b=0011:
  - All outputs return to reset values asynchronously.
  - No rsp_valid afterwards.
  - Next tie grants requester 0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU operation scheduler.
package alu_sched_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 2;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: full result/carry for non-shift ops, one-bit step for shifts.
module alu_core
    import alu_sched_pkg::*;
(
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic [WIDTH-1:0] o_step,
    output logic             o_step_carry
);

    logic [WIDTH:0] w_sum;

    assign w_sum = (WIDTH+1)'(i_a) + (WIDTH+1)'(i_b);

    always_comb begin
        o_result = i_a;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                o_result = i_a - i_b;
                o_carry  = (i_a >= i_b);
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            default: o_result = i_a;
        endcase
    end

    // Single shift step; the scheduler iterates it once per cycle.
    always_comb begin
        if (i_op == OP_SHR) begin
            o_step       = {1'b0, i_a[WIDTH-1:1]};
            o_step_carry = i_a[0];
        end else begin
            o_step       = {i_a[WIDTH-2:0], 1'b0};
            o_step_carry = i_a[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Round-robin arbiter and sequencer feeding a shared 4-bit ALU with a held response.
module alu_op_scheduler
    import alu_sched_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [OP_W-1:0]  req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic             r_last_grant;
    logic [OP_W-1:0]  r_op;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_id;
    logic             r_shift_c;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_carry;
    logic             r_rsp_zero;
    logic             r_busy;

    logic             w_grant;
    logic             w_xfer;
    logic             w_is_shift;
    req_t             w_req;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic [WIDTH-1:0] w_step;
    logic             w_step_carry;
    logic [WIDTH-1:0] w_final;
    logic             w_final_c;

    // On a tie the requester not granted last wins.
    assign w_grant = (&req_valid) ? ~r_last_grant : req_valid[1];

    always_comb begin
        req_ready = 2'b00;
        if (reset_n && (r_state == ST_IDLE) && (|req_valid)) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
    end

    assign w_xfer     = |(req_valid & req_ready);
    assign w_req      = w_grant ? req_t'{req_op1, req_a1, req_b1}
                                : req_t'{req_op0, req_a0, req_b0};
    assign w_is_shift = is_shift(r_op);
    assign w_final    = w_is_shift ? r_work : w_alu_result;
    assign w_final_c  = w_is_shift ? r_shift_c : w_alu_carry;

    alu_core u_alu_core (
        .i_op         (r_op),
        .i_a          (r_work),
        .i_b          (r_b),
        .o_result     (w_alu_result),
        .o_carry      (w_alu_carry),
        .o_step       (w_step),
        .o_step_carry (w_step_carry)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_xfer) w_next = ST_EXEC;
            ST_EXEC: if (!w_is_shift || (r_cnt == '0)) w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_op         <= OP_ADD;
            r_work       <= '0;
            r_b          <= '0;
            r_cnt        <= '0;
            r_id         <= 1'b0;
            r_shift_c    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy      <= (w_next != ST_IDLE);
            r_rsp_valid <= (w_next == ST_RESP);
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_op         <= w_req.op;
                        r_work       <= w_req.a;
                        r_b          <= w_req.b;
                        r_cnt        <= w_req.b[CNT_W-1:0];
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_shift_c    <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (w_is_shift && (r_cnt != '0)) begin
                        r_work    <= w_step;
                        r_shift_c <= w_step_carry;
                        r_cnt     <= r_cnt - CNT_W'(1);
                    end else begin
                        r_rsp_result <= w_final;
                        r_rsp_carry  <= w_final_c;
                        r_rsp_zero   <= (w_final == '0);
                        r_rsp_id     <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_zero   = r_rsp_zero;
    assign busy       = r_busy;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed self-checking bench for alu_op_scheduler.
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [OP_W-1:0]  req_op0, req_op1;
    logic [WIDTH-1:0] req_a0, req_a1, req_b0, req_b1;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, busy;
    logic [WIDTH-1:0] rsp_result;

    int n_tests = 0;
    int n_fail  = 0;

    alu_op_scheduler dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Counts edges until rsp_valid is seen at a falling edge; -1 if the bound expires.
    task automatic wait_rsp(input int max_edges, input logic [1:0] keep,
                            output int edges, output logic busy_all);
        edges    = -1;
        busy_all = 1'b1;
        for (int k = 1; k <= max_edges; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 1) req_valid = keep;
            if (rsp_valid === 1'b1) begin
                edges = k;
                break;
            end
            busy_all = busy_all & (busy === 1'b1);
        end
    endtask

    task automatic ack_rsp;
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        req_op0 = OP_ADD; req_a0 = '0; req_b0 = '0;
        req_op1 = OP_ADD; req_a1 = '0; req_b1 = '0;
        #12;
        n_tests++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready);
        end
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, busy} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b id=%b r=%b c=%b z=%b busy=%b expected all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL first_tie: got %b expected 01", req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_add;
        int   edges;
        logic busy_all;
        @(negedge clock);
        req_op0 = OP_ADD; req_a0 = 4'b0111; req_b0 = 4'b1010;
        req_valid = 2'b01;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL add_ready: got %b expected 01", req_ready);
        end
        wait_rsp(10, 2'b00, edges, busy_all);
        n_tests++;
        if (edges !== 2) begin
            n_fail++; $display("FAIL add_latency: got %0d expected 2", edges);
        end
        n_tests++;
        if ({rsp_result, rsp_carry, rsp_zero, rsp_id} !== {4'b0001, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_rsp: got r=%b c=%b z=%b id=%b expected r=0001 c=1 z=0 id=0",
                     rsp_result, rsp_carry, rsp_zero, rsp_id);
        end
        ack_rsp();
        n_tests++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL add_idle: got v=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_shl;
        int   edges;
        logic busy_all;
        @(negedge clock);
        req_op1 = OP_SHL; req_a1 = 4'b0110; req_b1 = 4'b0011;
        req_valid = 2'b10;
        #1;
        n_tests++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL shl_ready: got %b expected 10", req_ready);
        end
        wait_rsp(12, 2'b00, edges, busy_all);
        n_tests++;
        if (edges !== 5) begin
            n_fail++; $display("FAIL shl_latency: got %0d expected 5", edges);
        end
        n_tests++;
        if (busy_all !== 1'b1) begin
            n_fail++; $display("FAIL shl_busy: got %b expected 1", busy_all);
        end
        n_tests++;
        if ({rsp_result, rsp_carry, rsp_zero, rsp_id} !== {4'b0000, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL shl_rsp: got r=%b c=%b z=%b id=%b expected r=0000 c=1 z=1 id=1",
                     rsp_result, rsp_carry, rsp_zero, rsp_id);
        end
        ack_rsp();
    endtask

    task automatic test_sub_stall;
        int   edges;
        logic busy_all;
        @(negedge clock);
        req_op0 = OP_SUB;  req_a0 = 4'b0011; req_b0 = 4'b0101;
        req_op1 = OP_PASS; req_a1 = 4'b1001; req_b1 = 4'b0000;
        req_valid = 2'b01;
        wait_rsp(10, 2'b10, edges, busy_all);
        n_tests++;
        if ({rsp_result, rsp_carry, rsp_zero, rsp_id} !== {4'b1110, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_rsp: got r=%b c=%b z=%b id=%b expected r=1110 c=0 z=0 id=0",
                     rsp_result, rsp_carry, rsp_zero, rsp_id);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            n_tests++;
            if ({rsp_valid, rsp_result, rsp_carry, rsp_id, req_ready} !==
                {1'b1, 4'b1110, 1'b0, 1'b0, 2'b00}) begin
                n_fail++;
                $display("FAIL sub_stall%0d: got v=%b r=%b c=%b id=%b ready=%b expected 1 1110 0 0 00",
                         k, rsp_valid, rsp_result, rsp_carry, rsp_id, req_ready);
            end
        end
        ack_rsp();
        n_tests++;
        if ({busy, rsp_valid, req_ready} !== 4'b0010) begin
            n_fail++;
            $display("FAIL sub_release: got busy=%b v=%b ready=%b expected 0 0 10",
                     busy, rsp_valid, req_ready);
        end
        wait_rsp(10, 2'b00, edges, busy_all);
        n_tests++;
        if ({edges == 2, rsp_result, rsp_carry, rsp_id} !== {1'b1, 4'b1001, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL pass_rsp: got edges=%0d r=%b c=%b id=%b expected 2 1001 0 1",
                     edges, rsp_result, rsp_carry, rsp_id);
        end
        ack_rsp();
    endtask

    task automatic test_back_to_back;
        int               edges;
        logic             busy_all;
        logic             exp_id  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [WIDTH-1:0] exp_res [4] = '{4'b0011, 4'b0110, 4'b0011, 4'b0110};
        int               exp_e   [4] = '{2, 3, 3, 3};
        @(negedge clock);
        req_op0 = OP_ADD; req_a0 = 4'b0001; req_b0 = 4'b0010;
        req_op1 = OP_XOR; req_a1 = 4'b1100; req_b1 = 4'b1010;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(10, 2'b11, edges, busy_all);
            if (k == 3) req_valid = 2'b00;
            n_tests++;
            if ({edges == exp_e[k], rsp_id, rsp_result, rsp_carry} !==
                {1'b1, exp_id[k], exp_res[k], 1'b0}) begin
                n_fail++;
                $display("FAIL b2b%0d: got edges=%0d id=%b r=%b c=%b expected %0d %b %b 0",
                         k, edges, rsp_id, rsp_result, rsp_carry, exp_e[k], exp_id[k], exp_res[k]);
            end
        end
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int   edges;
        logic busy_all;
        logic saw_rsp;
        @(negedge clock);
        req_op0 = OP_SHR; req_a0 = 4'b1000; req_b0 = 4'b0011;
        req_valid = 2'b01;
        @(posedge clock);
        @(negedge clock);
        req_valid = 2'b00;
        @(posedge clock);
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL shr_exec_busy: got %b expected 1", busy);
        end
        #2;
        reset_n   = 1'b0;
        req_valid = 2'b11;
        #1;
        n_tests++;
        if ({busy, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, req_ready} !== 11'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%b v=%b id=%b r=%b c=%b z=%b ready=%b expected all 0",
                     busy, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, req_ready);
        end
        @(negedge clock);
        @(negedge clock);
        req_valid = 2'b00;
        reset_n   = 1'b1;
        saw_rsp   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            @(negedge clock);
            saw_rsp = saw_rsp | (rsp_valid !== 1'b0);
        end
        n_tests++;
        if (saw_rsp !== 1'b0) begin
            n_fail++; $display("FAIL discarded_rsp: got rsp_valid seen=%b expected 0", saw_rsp);
        end
        req_op0 = OP_AND; req_a0 = 4'b1100; req_b0 = 4'b1010;
        req_op1 = OP_OR;  req_a1 = 4'b0001; req_b1 = 4'b0010;
        req_valid = 2'b11;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL post_reset_tie: got %b expected 01", req_ready);
        end
        wait_rsp(10, 2'b00, edges, busy_all);
        n_tests++;
        if ({edges == 2, rsp_id, rsp_result, rsp_carry, rsp_zero} !== {1'b1, 1'b0, 4'b1000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_and: got edges=%0d id=%b r=%b c=%b z=%b expected 2 0 1000 0 0",
                     edges, rsp_id, rsp_result, rsp_carry, rsp_zero);
        end
        ack_rsp();
    endtask

    initial begin
        test_reset();
        test_add();
        test_shl();
        test_sub_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
